// File: rtl/ddr_rd_cmd_sched_if.sv
// Command-side bundle between the DDR3 read-command scheduler and its environment.
// The master modport is the scheduler; slave is whoever drives start/flags and consumes commands.
interface ddr_rd_cmd_sched_if #(
  parameter int unsigned ADDR_W = 28
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              loopback_buf_full;
  logic              app_rdy;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start,
    input  base_addr,
    input  loopback_buf_full,
    input  app_rdy,
    output app_en,
    output app_cmd,
    output app_addr,
    output busy,
    output frame_done
  );

  modport slave (
    output start,
    output base_addr,
    output loopback_buf_full,
    output app_rdy,
    input  app_en,
    input  app_cmd,
    input  app_addr,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/ddr_rd_cmd_sched.sv
// Issues a frame of MIG read commands in two-row packets, pausing before each packet
// until the loopback buffer reports room.
module ddr_rd_cmd_sched #(
  parameter int unsigned CMDS_PER_PKT = 5,
  parameter int unsigned FRAME_PKTS   = 360,
  parameter int unsigned ADDR_STEP    = 8,
  parameter int unsigned GAP          = 8,
  parameter int unsigned ADDR_W       = 28
) (
  input logic                 clk,
  input logic                 rst,
  ddr_rd_cmd_sched_if.master  bus
);

  localparam logic [3:0]        CmdLast  = 4'(CMDS_PER_PKT - 1);
  localparam logic [9:0]        PktLast  = 10'(FRAME_PKTS - 1);
  localparam logic [7:0]        GapLoad  = 8'(GAP - 1);
  localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StRdCmd,
    StPause
  } state_e;

  state_e            state_q;
  logic [3:0]        cmd_cnt_q;
  logic [9:0]        pkt_cnt_q;
  logic [7:0]        gap_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              en_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cmd_cnt_q <= '0;
      pkt_cnt_q <= '0;
      gap_cnt_q <= '0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            addr_q    <= bus.base_addr;
            cmd_cnt_q <= '0;
            pkt_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StCheck;
          end
        end
        // The full flag is only consulted here, so a packet once begun always completes.
        StCheck: begin
          if (!bus.loopback_buf_full) begin
            en_q    <= 1'b1;
            state_q <= StRdCmd;
          end
        end
        StRdCmd: begin
          if (bus.app_rdy) begin
            addr_q <= addr_q + AddrStep;
            if (cmd_cnt_q != CmdLast) begin
              cmd_cnt_q <= cmd_cnt_q + 4'd1;
            end else begin
              cmd_cnt_q <= '0;
              en_q      <= 1'b0;
              if (pkt_cnt_q == PktLast) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end else begin
                pkt_cnt_q <= pkt_cnt_q + 10'd1;
                gap_cnt_q <= GapLoad;
                state_q   <= StPause;
              end
            end
          end
        end
        // Gives the full flag time to cross back from the image-side clock.
        StPause: begin
          if (gap_cnt_q == 8'd0) begin
            state_q <= StCheck;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.app_en     = en_q;
  assign bus.app_cmd    = 3'b001;
  assign bus.app_addr   = addr_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_ddr_rd_cmd_sched.sv
// Scoreboard bench for ddr_rd_cmd_sched: expected addresses are queued when a start is
// accepted, and an event-level model of packet timing checks every cycle on the falling edge.
module tb_ddr_rd_cmd_sched;
  localparam int unsigned CPP   = 5;
  localparam int unsigned FP    = 2;
  localparam int unsigned STEP  = 8;
  localparam int unsigned GAPC  = 8;
  localparam int unsigned AW    = 28;
  localparam int unsigned TOTAL = CPP * FP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr_rd_cmd_sched_if #(.ADDR_W(AW)) bus ();

  ddr_rd_cmd_sched #(
    .CMDS_PER_PKT(CPP),
    .FRAME_PKTS  (FP),
    .ADDR_STEP   (STEP),
    .GAP         (GAPC),
    .ADDR_W      (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state, valid for the cycle currently being observed.
  logic [AW-1:0] exp_q[$];
  bit            mon_on     = 1'b0;
  bit            m_busy     = 1'b0;
  bit            m_done     = 1'b0;
  bit            waiting    = 1'b0;
  bit            in_pkt     = 1'b0;
  bit            prev_stall = 1'b0;
  bit            post_rst   = 1'b0;
  int            m_cnt      = 0;
  int            idle_k     = 0;
  int            thresh     = 0;
  int            exp_rise   = 0;
  int            acc_total  = 0;
  logic [AW-1:0] prev_addr  = '0;

  task automatic monitor_step();
    bit            nb;
    bit            nd;
    logic [AW-1:0] a;
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("frame_done", 32'(bus.frame_done), 32'(m_done));
    chk("app_cmd", 32'(bus.app_cmd), 32'h1);
    if (post_rst) begin
      chk("reset_app_en", 32'(bus.app_en), 32'h0);
      chk("reset_app_addr", 32'(bus.app_addr), 32'h0);
      post_rst = 1'b0;
    end else if (prev_stall) begin
      chk("stall_en_hold", 32'(bus.app_en), 32'h1);
      chk("stall_addr_hold", 32'(bus.app_addr), 32'(prev_addr));
    end
    // First command of a packet appears one cycle after the first eligible CHECK with full low.
    if (waiting) begin
      idle_k++;
      if (bus.app_en) begin
        chk("en_rise_cycle", 32'(idle_k), 32'(exp_rise));
        waiting = 1'b0;
        in_pkt  = 1'b1;
      end else begin
        if (exp_rise != 0 && idle_k == exp_rise) chk("en_rise_late", 32'(bus.app_en), 32'h1);
        if (exp_rise == 0 && idle_k >= thresh && !bus.loopback_buf_full) exp_rise = idle_k + 1;
      end
    end else begin
      chk("app_en_level", 32'(bus.app_en), 32'(in_pkt));
    end

    nb = m_busy;
    nd = 1'b0;
    if (rst) begin
      exp_q.delete();
      nb         = 1'b0;
      waiting    = 1'b0;
      in_pkt     = 1'b0;
      prev_stall = 1'b0;
      post_rst   = 1'b1;
    end else begin
      if (bus.app_en && bus.app_rdy) begin
        acc_total++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_accept: got addr 0x%0h, expected no command", bus.app_addr);
        end else begin
          a = exp_q.pop_front();
          chk("app_addr", 32'(bus.app_addr), 32'(a));
        end
        m_cnt++;
        if (m_cnt % CPP == 0) begin
          in_pkt = 1'b0;
          if (m_cnt >= TOTAL) begin
            nd = 1'b1;
            nb = 1'b0;
          end else begin
            waiting  = 1'b1;
            idle_k   = 0;
            thresh   = GAPC + 1;
            exp_rise = 0;
          end
        end
        prev_stall = 1'b0;
      end else begin
        prev_stall = bus.app_en;
      end
      prev_addr = bus.app_addr;
      if (bus.start && !m_busy) begin
        for (int i = 0; i < TOTAL; i++) exp_q.push_back(bus.base_addr + AW'(i * STEP));
        nb       = 1'b1;
        m_cnt    = 0;
        waiting  = 1'b1;
        idle_k   = 0;
        thresh   = 1;
        exp_rise = 0;
      end
    end
    m_busy = nb;
    m_done = nd;
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_on) monitor_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    bus.base_addr = base;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_en(input int budget);
    int n = 0;
    while (!bus.app_en && n < budget) begin
      tick();
      n++;
    end
    chk("en_seen_in_budget", 32'(n < budget), 32'h1);
  endtask

  task automatic wait_idle(input int budget, input bit rnd_rdy, input bit rnd_full,
                           input bit rnd_start);
    int n = 0;
    while ((m_busy || exp_q.size() != 0) && n < budget) begin
      if (rnd_rdy) bus.app_rdy = ($urandom_range(0, 3) != 0);
      if (rnd_full) bus.loopback_buf_full = ($urandom_range(0, 3) == 0);
      if (rnd_start) begin
        bus.start     = ($urandom_range(0, 15) == 0);
        bus.base_addr = AW'($urandom);
      end
      tick();
      n++;
    end
    bus.start = 1'b0;
    chk("frame_done_in_budget", 32'(n < budget), 32'h1);
    bus.app_rdy           = 1'b1;
    bus.loopback_buf_full = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n;
    bus.start             = 1'b0;
    bus.base_addr         = '0;
    bus.loopback_buf_full = 1'b0;
    bus.app_rdy           = 1'b1;
    rst                   = 1'b1;
    tick();
    tick();
    mon_on = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Basic frame
    pulse_start(28'h100);
    wait_idle(200, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Backpressure 1,0,0,1 in the first packet
    pulse_start(28'h2000);
    wait_en(20);
    tick();
    bus.app_rdy = 1'b0;
    tick();
    tick();
    bus.app_rdy = 1'b1;
    wait_idle(200, 1'b0, 1'b0, 1'b0);
    pulse_start(28'h3000);
    wait_idle(400, 1'b1, 1'b0, 1'b0);

    // Buffer full raised mid-packet 1 and held across the gap
    pulse_start(28'h4000);
    wait_en(20);
    tick();
    tick();
    bus.loopback_buf_full = 1'b1;
    repeat (3 + GAPC + 20) tick();
    bus.loopback_buf_full = 1'b0;
    wait_idle(200, 1'b0, 1'b0, 1'b0);

    // Address wrap
    pulse_start(28'hFFFFFF8);
    wait_idle(200, 1'b0, 1'b0, 1'b0);

    // Start while busy
    pulse_start(28'h500);
    repeat (7) tick();
    pulse_start(28'h9000);
    wait_idle(200, 1'b0, 1'b0, 1'b0);

    // Reset after the third accept, then restart
    pulse_start(28'h700);
    n0 = acc_total;
    n  = 0;
    while (acc_total - n0 < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("third_accept_in_budget", 32'(n < 50), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_start(28'h40);
    wait_idle(200, 1'b0, 1'b0, 1'b0);

    // Randomized frames with stray starts
    for (int f = 0; f < 6; f++) begin
      pulse_start(AW'($urandom));
      wait_idle(800, 1'b1, 1'b1, 1'b1);
    end
    wait_idle(800, 1'b0, 1'b0, 1'b0);

    repeat (5) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    chk("idle_at_end", 32'(bus.busy), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
